// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vga_pkg
//  Description : Shared VGA timing constants, colour/coordinate types.
//  Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef logic [7:0]  color_t;
  typedef logic [10:0] coord_t;

  localparam color_t VGA_MASK_VALUE = 8'h62;
  localparam color_t VGA_BG_COLOR   = 8'h00;

endpackage
`default_nettype wire

// File: rtl/vga_timing_counter.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_counter
//  Description : Free-running h/v scan counters with frame_start and raw
//                (undelayed) active / hsync / vsync decodes.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic   clk,
  input  logic   reset,
  output coord_t o_h_count,
  output coord_t o_v_count,
  output logic   o_frame_start,
  output logic   o_raw_active,
  output logic   o_raw_hsync_n,
  output logic   o_raw_vsync_n
);

  localparam coord_t c_H_ACT      = coord_t'(H_ACTIVE);
  localparam coord_t c_H_SYNC_BEG = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t c_H_SYNC_END = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t c_H_LAST     = coord_t'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t c_V_ACT      = coord_t'(V_ACTIVE);
  localparam coord_t c_V_SYNC_BEG = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t c_V_SYNC_END = coord_t'(V_ACTIVE + V_FP + V_SYNC);
  localparam coord_t c_V_LAST     = coord_t'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  coord_t r_h;
  coord_t r_v;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h <= '0;
      r_v <= '0;
    end else if (r_h == c_H_LAST) begin
      r_h <= '0;
      r_v <= (r_v == c_V_LAST) ? '0 : r_v + 11'd1;
    end else begin
      r_h <= r_h + 11'd1;
    end
  end

  assign o_h_count     = r_h;
  assign o_v_count     = r_v;
  // First line of vertical blanking; the wrap to (0,0) never matches this.
  assign o_frame_start = (r_h == '0) && (r_v == c_V_ACT);
  assign o_raw_active  = (r_h < c_H_ACT) && (r_v < c_V_ACT);
  assign o_raw_hsync_n = !((r_h >= c_H_SYNC_BEG) && (r_h < c_H_SYNC_END));
  assign o_raw_vsync_n = !((r_v >= c_V_SYNC_BEG) && (r_v < c_V_SYNC_END));

endmodule
`default_nettype wire

// File: rtl/vga_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : vga_layer_compositor
//  Description : Scan initiator and fixed-priority layer compositor driving
//                VGA colour/sync. Optional per-frame collision flags are
//                built when COLLISION_DETECT_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int     H_ACTIVE   = VGA_H_ACTIVE,
  parameter int     H_FP       = VGA_H_FP,
  parameter int     H_SYNC     = VGA_H_SYNC,
  parameter int     H_BP       = VGA_H_BP,
  parameter int     V_ACTIVE   = VGA_V_ACTIVE,
  parameter int     V_FP       = VGA_V_FP,
  parameter int     V_SYNC     = VGA_V_SYNC,
  parameter int     V_BP       = VGA_V_BP,
  parameter int     NUM_LAYERS = 4,
  parameter color_t MASK_VALUE = VGA_MASK_VALUE,
  parameter color_t BG_COLOR   = VGA_BG_COLOR
) (
  input  logic                        clk,
  input  logic                        reset,
  output coord_t                      requested_x,
  output coord_t                      requested_y,
  output logic                        frame_start,
  input  color_t [NUM_LAYERS-1:0]     layer_color,
  output color_t                      out_color,
  output logic                        blank_n,
  output logic                        hsync,
  output logic                        vsync,
  output logic   [NUM_LAYERS-2:0]     collision_flags
);

  logic w_frame_start;
  logic w_raw_active;
  logic w_raw_hsync_n;
  logic w_raw_vsync_n;

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk           (clk),
    .reset         (reset),
    .o_h_count     (requested_x),
    .o_v_count     (requested_y),
    .o_frame_start (w_frame_start),
    .o_raw_active  (w_raw_active),
    .o_raw_hsync_n (w_raw_hsync_n),
    .o_raw_vsync_n (w_raw_vsync_n)
  );

  assign frame_start = w_frame_start;

  logic [NUM_LAYERS-1:0] w_opaque;

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_opaque
    assign w_opaque[k] = (layer_color[k] != MASK_VALUE);
  end

  // Walk from lowest to highest priority so the lowest opaque index wins.
  color_t w_pick;
  always_comb begin
    w_pick = BG_COLOR;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (w_opaque[k]) begin
        w_pick = layer_color[k];
      end
    end
  end

  logic   r_active_d1;
  logic   r_hsync_n_d1;
  logic   r_vsync_n_d1;
  color_t r_color;
  logic   r_blank_n;
  logic   r_hsync;
  logic   r_vsync;

  // Stage 1 aligns scan decodes with the layer replies; stage 2 is the output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active_d1  <= 1'b0;
      r_hsync_n_d1 <= 1'b1;
      r_vsync_n_d1 <= 1'b1;
      r_color      <= '0;
      r_blank_n    <= 1'b0;
      r_hsync      <= 1'b1;
      r_vsync      <= 1'b1;
    end else begin
      r_active_d1  <= w_raw_active;
      r_hsync_n_d1 <= w_raw_hsync_n;
      r_vsync_n_d1 <= w_raw_vsync_n;
      r_color      <= r_active_d1 ? w_pick : '0;
      r_blank_n    <= r_active_d1;
      r_hsync      <= r_hsync_n_d1;
      r_vsync      <= r_vsync_n_d1;
    end
  end

  assign out_color = r_color;
  assign blank_n   = r_blank_n;
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;

`ifdef COLLISION_DETECT_EN
  logic [NUM_LAYERS-2:0] w_hit;
  logic [NUM_LAYERS-2:0] r_sticky;
  logic [NUM_LAYERS-2:0] r_flags;

  assign w_hit = {(NUM_LAYERS-1){r_active_d1 & w_opaque[0]}} & w_opaque[NUM_LAYERS-1:1];

  // frame_start sits in blanking, so no hit can be lost at the clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sticky <= '0;
      r_flags  <= '0;
    end else if (w_frame_start) begin
      r_flags  <= r_sticky;
      r_sticky <= '0;
    end else begin
      r_sticky <= r_sticky | w_hit;
    end
  end

  assign collision_flags = r_flags;
`else
  assign collision_flags = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_layer_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_layer_compositor
//  Description : Directed self-checking bench; full horizontal timing with a
//                shortened vertical frame to keep frames short.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_layer_compositor;

  localparam int H_ACT = 640;
  localparam int H_TOT = 800;
  localparam int V_ACT = 12;
  localparam int V_FP  = 2;
  localparam int V_SYN = 2;
  localparam int V_BP  = 3;
  localparam int V_TOT = V_ACT + V_FP + V_SYN + V_BP;
  localparam int FRAME = H_TOT * V_TOT;
  localparam int WAIT_LIMIT = 20000;

`ifdef COLLISION_DETECT_EN
  localparam logic [2:0] EXP_HIT = 3'b010;
`else
  localparam logic [2:0] EXP_HIT = 3'b000;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [10:0]     requested_x;
  logic [10:0]     requested_y;
  logic            frame_start;
  logic [3:0][7:0] layer_color;
  logic [7:0]      out_color;
  logic            blank_n;
  logic            hsync;
  logic            vsync;
  logic [2:0]      collision_flags;

  int checks = 0;
  int errors = 0;

  vga_layer_compositor #(
    .V_ACTIVE (V_ACT),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYN),
    .V_BP     (V_BP)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .requested_x     (requested_x),
    .requested_y     (requested_y),
    .frame_start     (frame_start),
    .layer_color     (layer_color),
    .out_color       (out_color),
    .blank_n         (blank_n),
    .hsync           (hsync),
    .vsync           (vsync),
    .collision_flags (collision_flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_layers(input logic [7:0] l0, input logic [7:0] l1,
                            input logic [7:0] l2, input logic [7:0] l3);
    layer_color[0] = l0;
    layer_color[1] = l1;
    layer_color[2] = l2;
    layer_color[3] = l3;
  endtask

  task automatic wait_req(input int x, input int y);
    int n = 0;
    while (!(int'(requested_x) == x && int'(requested_y) == y) && n < WAIT_LIMIT) begin
      tick();
      n++;
    end
    check("wait_req_in_time", {31'b0, (n < WAIT_LIMIT)}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_x"},       requested_x, 0);
    check({tag, "_y"},       requested_y, 0);
    check({tag, "_fs"},      frame_start, 0);
    check({tag, "_color"},   out_color, 0);
    check({tag, "_blank_n"}, blank_n, 0);
    check({tag, "_hsync"},   hsync, 1);
    check({tag, "_vsync"},   vsync, 1);
    check({tag, "_flags"},   collision_flags, 0);
  endtask

  initial begin
    int ex, ey, dx1, dy1, dx2, dy2, fs_cnt, prev_ry;
    bit wrap_seen;

    reset = 1'b1;
    set_layers(8'h62, 8'h62, 8'h62, 8'h62);
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // Release and first two scan positions
    reset = 1'b0;
    #1;
    check("rel_x0", requested_x, 0);
    check("rel_y0", requested_y, 0);
    check("rel_blank0", blank_n, 0);
    tick();
    check("rel_x1", requested_x, 1);
    check("rel_y1", requested_y, 0);
    check("rel_blank1", blank_n, 0);
    tick();
    check("rel_blank2", blank_n, 1);
    check("rel_bg", out_color, 8'h00);

    // One full frame against a coordinate/sync model
    ex = 2; ey = 0; dx2 = 0; dy2 = 0; dx1 = 1; dy1 = 0;
    fs_cnt = 0; wrap_seen = 1'b0; prev_ry = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (i > 0 && prev_ry == V_TOT - 1 && requested_y == 11'd0) wrap_seen = 1'b1;
      prev_ry = int'(requested_y);
      check("scan_x", requested_x, ex);
      check("scan_y", requested_y, ey);
      check("blank_n", blank_n, {31'b0, (dx2 < H_ACT && dy2 < V_ACT)});
      check("hsync", hsync, {31'b0, !(dx2 >= 656 && dx2 < 752)});
      check("vsync", vsync, {31'b0, !(dy2 >= V_ACT + V_FP && dy2 < V_ACT + V_FP + V_SYN)});
      check("out_bg", out_color, 0);
      check("frame_start", frame_start, {31'b0, (ex == 0 && ey == V_ACT)});
      if (frame_start) fs_cnt++;
      dx2 = dx1; dy2 = dy1; dx1 = ex; dy1 = ey;
      if (ex == H_TOT - 1) begin
        ex = 0;
        ey = (ey == V_TOT - 1) ? 0 : ey + 1;
      end else begin
        ex++;
      end
      tick();
    end
    check("frame_start_count", fs_cnt, 1);
    check("y_wrap_seen", {31'b0, wrap_seen}, 1);

    // Priority patterns on active pixels of frame 2
    wait_req(10, 1);
    set_layers(8'h62, 8'h62, 8'h1C, 8'hE0);
    repeat (3) tick();
    check("prio_layer2", out_color, 8'h1C);
    check("prio_blank", blank_n, 1);
    set_layers(8'h62, 8'h5A, 8'h62, 8'h62);
    repeat (3) tick();
    check("prio_layer1", out_color, 8'h5A);
    set_layers(8'h33, 8'h62, 8'h62, 8'h62);
    repeat (3) tick();
    check("prio_layer0", out_color, 8'h33);
    set_layers(8'h62, 8'h62, 8'h62, 8'h62);
    repeat (3) tick();
    check("all_masked_bg", out_color, 8'h00);

    // Horizontal blanking forces colour to zero
    wait_req(698, 1);
    set_layers(8'h33, 8'h44, 8'h55, 8'h66);
    repeat (4) tick();
    check("hblank_color", out_color, 0);
    check("hblank_blank_n", blank_n, 0);
    check("hblank_hsync", hsync, 0);
    set_layers(8'h62, 8'h62, 8'h62, 8'h62);

    // Layer 0 and layer 2 overlap for the single pixel (100,5)
    wait_req(101, 5);
    set_layers(8'h11, 8'h62, 8'h22, 8'h62);
    tick();
    check("overlap_color", out_color, 8'h11);
    set_layers(8'h62, 8'h62, 8'h62, 8'h62);
    wait_req(0, V_ACT);
    check("fs_at_vblank", frame_start, 1);
    check("flags_before_load", collision_flags, 0);
    tick();
    check("flags_after_hit", collision_flags, EXP_HIT);
    check("fs_one_cycle", frame_start, 0);

    // Clean frame clears the flags
    wait_req(0, V_ACT);
    tick();
    check("flags_clean_frame", collision_flags, 0);

    // All layers opaque: layer 0 wins
    wait_req(50, 2);
    set_layers(8'h33, 8'h44, 8'h55, 8'h66);
    repeat (3) tick();
    check("overlap_prio", out_color, 8'h33);
    set_layers(8'h44, 8'h62, 8'h62, 8'h62);

    // Mid-frame asynchronous reset
    wait_req(300, 3);
    check("pre_reset_color", out_color, 8'h44);
    check("pre_reset_blank", blank_n, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check("resume_x0", requested_x, 0);
    check("resume_y0", requested_y, 0);
    tick();
    check("resume_x1", requested_x, 1);
    check("resume_y1", requested_y, 0);
    check("resume_blank", blank_n, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
